// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package arm_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_e;

  localparam int SRAM_BASE_ADDR = 1024;
  localparam int SRAM_DW        = 16;
  localparam int SRAM_AW        = 18;
endpackage

// File: rtl/sram_mem_ctrl_wait_cnt.sv
// Wait-state counter for one half-word phase; tc flags the last wait cycle.
module sram_wait_cnt #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == 4'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: 32-bit LDR/STR as two 16-bit async SRAM phases.
// Optional one-entry read cache: define SRAM_MEM_CTRL_RD_CACHE_EN.
module sram_mem_ctrl
  import arm_pkg::*;
#(
  parameter int BASE_ADDR   = SRAM_BASE_ADDR,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = arm_pkg::SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        st_val,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);
  localparam int IW = SRAM_AW - 1;

  mem_state_e          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, idx_in;
  logic [31:0]         st_q, st_d, rd_q, rd_d, off;
  logic                wr_q, wr_d, req, tc, cnt_clr, cnt_en, phase_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [SRAM_DW-1:0]  dq_q, dq_d;
  logic                we_n_q, we_n_d, oe_q, oe_d;
  logic                hit;
  logic [31:0]         hit_data;

  // Wraps modulo 2^32 for addresses below the base; byte offset bits dropped.
  assign off    = alu_res - 32'(BASE_ADDR);
  assign idx_in = off[IW+1:2];
  assign req    = mem_r_en | mem_w_en;

  sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    st_d    = st_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          idx_d   = idx_in;
          st_d    = st_val;
          wr_d    = mem_w_en;
          state_d = LO;
          if (hit) begin
            rd_d    = hit_data;
            state_d = DONE;
          end
        end
      end
      LO: begin
        cnt_en = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          if (!wr_q) rd_d[15:0] = sram_dq_in;
          state_d = HI;
        end
      end
      HI: begin
        cnt_en = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          if (!wr_q) rd_d[31:16] = sram_dq_in;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered from the next state so they are glitch-free.
    phase_d = (state_d == LO) || (state_d == HI);
    we_n_d  = ~(phase_d & wr_d);
    oe_d    = ~we_n_d;
    addr_d  = '0;
    dq_d    = '0;
    if (phase_d) addr_d = {idx_d, (state_d == HI)};
    if (!we_n_d) dq_d = (state_d == HI) ? st_d[31:16] : st_d[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      st_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
    end
  end

`ifdef SRAM_MEM_CTRL_RD_CACHE_EN
  logic          c_vld_q, c_vld_d;
  logic [IW-1:0] c_idx_q, c_idx_d;
  logic [31:0]   c_data_q, c_data_d;

  assign hit      = ~mem_w_en & c_vld_q & (c_idx_q == idx_in);
  assign hit_data = c_data_q;

  always_comb begin
    c_vld_d  = c_vld_q;
    c_idx_d  = c_idx_q;
    c_data_d = c_data_q;
    if (state_q == DONE) begin
      if (!wr_q) begin
        c_vld_d  = 1'b1;
        c_idx_d  = idx_q;
        c_data_d = rd_q;
      end else if (c_vld_q && c_idx_q == idx_q) begin
        c_data_d = st_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld_q  <= 1'b0;
      c_idx_q  <= '0;
      c_data_q <= '0;
    end else begin
      c_vld_q  <= c_vld_d;
      c_idx_q  <= c_idx_d;
      c_data_q <= c_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign ready       = ((state_q == IDLE) & ~req) | (state_q == DONE);
  assign read_data   = rd_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, each on its own SRAM model.
module tb_sram_mem_ctrl;
`ifdef SRAM_MEM_CTRL_RD_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        r1, w1, r3, w3;
  logic [31:0] a1, d1, a3, d3;
  logic        rdy1, rdy3, oe1, oe3, we1, we3;
  logic [31:0] rd1, rd3;
  logic [17:0] addr1, addr3;
  logic [15:0] dqo1, dqo3, dqi1, dqi3;

  logic [15:0] mem1 [0:(1<<18)-1];
  logic [15:0] mem3 [0:(1<<18)-1];

  sram_mem_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(w1), .alu_res(a1), .st_val(d1),
    .ready(rdy1), .read_data(rd1), .sram_addr(addr1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(we1));

  sram_mem_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(3), .SRAM_AW(18)) dut3 (
    .clk(clk), .rst(rst), .mem_r_en(r3), .mem_w_en(w3), .alu_res(a3), .st_val(d3),
    .ready(rdy3), .read_data(rd3), .sram_addr(addr3), .sram_dq_out(dqo3),
    .sram_dq_in(dqi3), .sram_dq_oe(oe3), .sram_we_n(we3));

  assign dqi1 = mem1[addr1];
  assign dqi3 = mem3[addr3];
  always @(posedge clk) begin
    if (!we1) mem1[addr1] <= dqo1;
    if (!we3) mem3[addr3] <= dqo3;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [17:0] addr_log [16];
  logic [15:0] dq_log   [16];
  logic        done_we, done_oe;

  // Called just after a rising edge; returns after the DONE cycle's edge.
  task automatic access(input bit sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lowc, output int wel,
                        output int oel, output logic [31:0] rd);
    if (sel) begin r3 = r; w3 = w; a3 = a; d3 = d; end
    else     begin r1 = r; w1 = w; a1 = a; d1 = d; end
    lowc = 0; wel = 0; oel = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel ? rdy3 : rdy1) break;
      if (lowc < 16) begin
        addr_log[lowc] = sel ? addr3 : addr1;
        dq_log[lowc]   = sel ? dqo3 : dqo1;
      end
      lowc++;
      if (!(sel ? we3 : we1)) wel++;
      if (sel ? oe3 : oe1) oel++;
    end
    rd      = sel ? rd3 : rd1;
    done_we = sel ? we3 : we1;
    done_oe = sel ? oe3 : oe1;
    @(posedge clk); #1;
    if (sel) begin r3 = 0; w3 = 0; end
    else     begin r1 = 0; w1 = 0; end
  endtask

  initial begin
    int lowc, wel, oel, bad;
    logic [31:0] rd;
    for (int i = 0; i < (1 << 18); i++) begin mem1[i] = '0; mem3[i] = '0; end
    r1 = 0; w1 = 0; a1 = 0; d1 = 0; r3 = 0; w3 = 0; a3 = 0; d3 = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy1, 1);
    chk("rst_we_n", we1, 1);
    chk("rst_oe", oe1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_rdata", rd1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0x12345678 to 1024
    access(0, 0, 1, 1024, 32'h1234_5678, lowc, wel, oel, rd);
    chk("wr_lat", lowc, 3);
    chk("wr_we_cycles", wel, 2);
    chk("wr_oe_cycles", oel, 2);
    chk("wr_lo_addr", addr_log[1], 0);
    chk("wr_lo_dq", dq_log[1], 16'h5678);
    chk("wr_hi_addr", addr_log[2], 1);
    chk("wr_hi_dq", dq_log[2], 16'h1234);
    chk("wr_done_we", done_we, 1);
    chk("wr_done_oe", done_oe, 0);

    // Read it back
    access(0, 1, 0, 1024, 0, lowc, wel, oel, rd);
    chk("rd_lat", lowc, 3);
    chk("rd_data", rd, 32'h1234_5678);
    chk("rd_we_cycles", wel, 0);
    chk("rd_oe_cycles", oel, 0);

    // Both enables: write to half-words 4/5, read_data untouched
    access(0, 1, 1, 1032, 32'hAABB_CCDD, lowc, wel, oel, rd);
    chk("prio_we_cycles", wel, 2);
    chk("prio_lo_addr", addr_log[1], 4);
    chk("prio_hi_addr", addr_log[2], 5);
    chk("prio_rdata", rd, 32'h1234_5678);
    chk("prio_mem", {mem1[5], mem1[4]}, 32'hAABB_CCDD);

    // Below-base address wraps into the top of the SRAM
    access(0, 0, 1, 1020, 32'h0BAD_F00D, lowc, wel, oel, rd);
    chk("wrap_lo_addr", addr_log[1], 18'h3FFFE);
    chk("wrap_hi_addr", addr_log[2], 18'h3FFFF);

    // Idle for 10 cycles
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rdy1 || !we1) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    @(posedge clk); #1;

    // Back-to-back reads of 1040 and 1044
    mem1[8] = 16'h2222; mem1[9] = 16'h1111; mem1[10] = 16'h4444; mem1[11] = 16'h3333;
    access(0, 1, 0, 1040, 0, lowc, wel, oel, rd);
    chk("b2b0_lat", lowc, 3);
    chk("b2b0_data", rd, 32'h1111_2222);
    access(0, 1, 0, 1044, 0, lowc, wel, oel, rd);
    chk("b2b1_lat", lowc, 3);
    chk("b2b1_data", rd, 32'h3333_4444);
    @(negedge clk);
    chk("no_reissue_ready", rdy1, 1);
    @(posedge clk); #1;

    // Byte offset bits ignored
    access(0, 1, 0, 1027, 0, lowc, wel, oel, rd);
    chk("lowbits_lat", lowc, 3);
    chk("lowbits_data", rd, 32'h1234_5678);

    // Repeat read (cache hit when enabled), then write-through update
    access(0, 1, 0, 1024, 0, lowc, wel, oel, rd);
    chk("rep_lat", lowc, HIT_LAT);
    chk("rep_data", rd, 32'h1234_5678);
    access(0, 0, 1, 1024, 32'hCAFE_F00D, lowc, wel, oel, rd);
    chk("upd_we_cycles", wel, 2);
    access(0, 1, 0, 1024, 0, lowc, wel, oel, rd);
    chk("upd_lat", lowc, HIT_LAT);
    chk("upd_data", rd, 32'hCAFE_F00D);

    // WAIT_CYCLES=3 read
    mem3[4] = 16'hBEEF; mem3[5] = 16'hDEAD;
    access(1, 1, 0, 1032, 0, lowc, wel, oel, rd);
    chk("w3_rd_lat", lowc, 7);
    chk("w3_rd_data", rd, 32'hDEAD_BEEF);

    // WAIT_CYCLES=3 write aborted by reset during HI
    w3 = 1; a3 = 1024; d3 = 32'h1111_2222;
    repeat (5) @(negedge clk);
    chk("w3_hi_addr", addr3, 1);
    chk("w3_hi_we_n", we3, 0);
    rst = 1'b1; w3 = 0;
    @(negedge clk);
    chk("abort_ready", rdy3, 1);
    chk("abort_we_n", we3, 1);
    chk("abort_oe", oe3, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-stage controller directly downstream of the execute-stage ALU.
- Consumes the ALU result as the byte address for LDR/STR and performs a 32-bit word access on an external 16-bit asynchronous SRAM as two half-word phases with programmable wait states.
- Holds `ready` low to freeze the pipeline until the access completes.
- Returns load data to the write-back path.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1: cycles per half-word phase; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request (LDR).
- mem_w_en  in  1  store request (STR).
- alu_res  in  32  byte address from the ALU (alu_out).
- st_val  in  32  store data.
- ready  out  1  1 = access complete or idle; 0 = stall the pipeline.
- read_data  out  32  load result.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  active-low write enable.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, counter 0, read_data 0, latched address and data 0, sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0.
- Request definition: req = mem_r_en | mem_w_en. If both are asserted, the access is a write; mem_r_en is ignored.
- Word index: idx = (alu_res - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half-word lives at address {idx,0}; high half-word at {idx,1}.
  - alu_res[1:0] is ignored.
  - Addresses below BASE_ADDR wrap modulo 2^32 before the shift; no error is raised.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if req, latch idx, st_val and is_write; clear counter; go to LO. Otherwise stay.
  - LO: drive {idx,0}. For a write, sram_dq_out = st_val[15:0], oe = 1, we_n = 0. Counter increments each cycle. When counter == WAIT_CYCLES-1: for a read, capture sram_dq_in into read_data[15:0]; clear counter; go to HI.
  - HI: same as LO, using {idx,1} and st_val[31:16] / read_data[31:16]; go to DONE.
  - DONE: we_n = 1, oe = 0; go to IDLE unconditionally.
- ready (combinational): ready = (IDLE & ~req) | DONE.
- Latency: ready is low for exactly 2*WAIT_CYCLES+1 cycles, counting from the cycle req is first seen in IDLE. It is high in DONE; read_data is valid from DONE onward and holds until the next read's capture.
- Upstream contract: upstream holds mem_r_en, mem_w_en, alu_res and st_val stable while ready = 0. The controller uses only latched copies after IDLE.
- No double issue: DONE always returns to IDLE. A request still present in DONE is not re-issued; the next access starts only when IDLE sees req after the pipeline has advanced.
- Back-to-back requests: IDLE to LO without an idle gap.
- Write strobe: sram_we_n is low for the whole LO and HI phases of a write and high at all other times. sram_dq_oe equals ~sram_we_n.
- Reset mid-operation: abort immediately at the next edge. State returns to IDLE, we_n 1, oe 0. A partial write is not completed or rolled back.

Optional Feature:
- Macro: SRAM_MEM_CTRL_RD_CACHE_EN.
- When defined: a one-entry read cache holds a valid bit, idx and a 32-bit word.
  - A read in IDLE whose idx matches a valid entry goes IDLE→DONE directly, loading read_data from the cache. ready is low 1 cycle.
  - Every completed read fills the entry.
  - A write to a matching idx updates the entry with st_val at DONE.
  - rst clears the valid bit.
- When undefined: no cache logic; every read takes the full SRAM sequence.

Decomposition:
- Shared package arm_pkg holds:
  - the FSM state enum (IDLE, LO, HI, DONE);
  - SRAM_BASE_ADDR = 1024;
  - SRAM_DW = 16 and the default SRAM_AW = 18.
- One natural sub-module, sram_wait_cnt: a 4-bit counter with clear/enable inputs and a terminal-count output compared against WAIT_CYCLES.

Test Plan:
- Write, WAIT_CYCLES=1: mem_w_en=1, alu_res=1024, st_val=0x12345678 → sram_addr 0 with dq_out 0x5678 and we_n=0 for 1 cycle, then addr 1 with dq_out 0x1234. ready low 3 cycles, then high.
- Read back from an SRAM model: mem_r_en=1, alu_res=1024 → read_data=0x12345678 in DONE. we_n stays 1 and oe stays 0 throughout.
- Priority and mapping: mem_r_en=mem_w_en=1, alu_res=1032 → treated as a write to half-words 4/5. read_data is unchanged.
- Idle and back-to-back: no request for 10 cycles → ready=1, we_n=1 throughout. Two consecutive reads, each held until its own ready → each read issued exactly once; no re-issue on the DONE cycle.
- WAIT_CYCLES=3 and reset: read ready is low 7 cycles. rst asserted during HI of a write → next cycle IDLE, we_n=1, oe=0, ready=1.
- With SRAM_MEM_CTRL_RD_CACHE_EN: repeat read of 1024 → ready low 1 cycle, read_data correct. Write 0xCAFEF00D to 1024, then read → 0xCAFEF00D.
